// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage feeding decode from a combinational-read instruction memory.
// Latency: address driven in cycle N, {pc, instruction} valid on the output register in cycle N+1.
// Backpressure: one-entry valid/ready output register; pc and output hold while out_valid && !out_ready.
// Optional accepted-instruction counter built only when FETCH_COUNT_EN is defined.
module instruction_fetch #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 256,
    parameter int RESET_PC  = 0,
    parameter int LAST_PC   = 199
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] inst_address,
    input  logic [DATA_W-1:0] read_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              busy,
    output logic              done,
    output logic [31:0]       fetch_count
);

    // pc lives in a power-of-two address space, so wrapping is a mask
    localparam logic [ADDR_W-1:0] PC_MASK    = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] LAST_PC_A  = ADDR_W'(LAST_PC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_inst_q;
    logic [ADDR_W-1:0] out_pc_q;

    // Helper terms shared by the FSM and the counter
    logic              handshake;
    logic              load;
    logic              redirect_take;
    logic              start_take;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] redirect_pc_d;

    // Decode of the current cycle's events; redirect is only honoured once running
    always_comb begin
        handshake     = out_valid_q && out_ready;
        load          = !out_valid_q || out_ready;
        redirect_take = redirect_valid && (state_q != IDLE);
        // start is ignored while running, and loses to a redirect in DONE
        start_take    = start && ((state_q == IDLE) ||
                                  ((state_q == DONE) && !redirect_valid));
        pc_d          = (pc_q + ADDR_W'(1)) & PC_MASK;
        redirect_pc_d = redirect_pc & PC_MASK;
    end

    // Fetch FSM and output register: reset > redirect > start > sequential fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC_A;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        out_valid_q <= 1'b0;
                    end
                    if (start_take) begin
                        state_q <= RUN;
                        pc_q    <= RESET_PC_A;
                    end
                end
                RUN: begin
                    if (redirect_take) begin
                        // Squash whatever is held; a same-cycle handshake already consumed it
                        pc_q        <= redirect_pc_d;
                        out_valid_q <= 1'b0;
                    end else if (load) begin
                        out_inst_q  <= read_data;
                        out_pc_q    <= pc_q;
                        out_valid_q <= 1'b1;
                        if (pc_q == LAST_PC_A) begin
                            // Last word fetched: park with pc pointing at it
                            state_q <= DONE;
                        end else begin
                            pc_q <= pc_d;
                        end
                    end
                end
                DONE: begin
                    if (redirect_take) begin
                        state_q     <= RUN;
                        pc_q        <= redirect_pc_d;
                        out_valid_q <= 1'b0;
                    end else begin
                        // Let decode drain the final instruction
                        if (handshake) begin
                            out_valid_q <= 1'b0;
                        end
                        if (start_take) begin
                            state_q <= RUN;
                            pc_q    <= RESET_PC_A;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign inst_address = pc_q;
    assign out_valid    = out_valid_q;
    assign out_inst     = out_inst_q;
    assign out_pc       = out_pc_q;
    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE);

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count_q;

    // Count every delivered instruction; a fresh start begins a new tally
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= '0;
        end else if (start_take) begin
            fetch_count_q <= '0;
        end else if (handshake) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized run against a delivery-order model.
// Inputs change and outputs are sampled on the falling edge; the DUT updates on the rising edge.
// Works with or without FETCH_COUNT_EN defined.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset, start, redirect_valid, out_ready;
    logic [15:0] redirect_pc, inst_address, out_pc;
    logic [31:0] read_data, out_inst, fetch_count;
    logic        out_valid, busy, done;

    logic [31:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign read_data = mem[inst_address[7:0]];

    instruction_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .inst_address   (inst_address),
        .read_data      (read_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .busy           (busy),
        .done           (done),
        .fetch_count    (fetch_count)
    );

    function automatic logic [31:0] word(input int k);
        return 32'h1000_0000 + 32'(k);
    endfunction

    // Apply one cycle of inputs and move to the next sampling point
    task automatic step(input logic rdy, input logic rv, input logic [15:0] rpc,
                        input logic st, input logic rst);
        reset = rst; start = st; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic restart();
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        checks++;
        if ({out_valid, busy, done} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {out_valid, busy, done});
        end
        checks++;
        if (inst_address !== 16'h0 || out_pc !== 16'h0) begin
            errors++; $display("FAIL reset_addr got addr=%h pc=%h want 0/0", inst_address, out_pc);
        end
        checks++;
        if (out_inst !== 32'h0 || fetch_count !== 32'h0) begin
            errors++; $display("FAIL reset_data got inst=%h cnt=%0d want 0/0", out_inst, fetch_count);
        end
    endtask

    task automatic test_stream();
        restart();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || inst_address !== 16'h0) begin
            errors++; $display("FAIL stream_first got busy=%b vld=%b addr=%h want 1/0/0", busy, out_valid, inst_address);
        end
        for (int i = 0; i < 12; i++) begin
            // start while running must not disturb the sequence
            step(1'b1, 1'b0, 16'h0, (i == 5), 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 16'(i) || out_inst !== word(i)) begin
                errors++; $display("FAIL stream_%0d got vld=%b pc=%h inst=%h want 1/%h/%h", i, out_valid, out_pc, out_inst, 16'(i), word(i));
            end
        end
    endtask

    task automatic test_stall();
        restart();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 16'd5 || out_inst !== word(5) || inst_address !== 16'd6) begin
                errors++; $display("FAIL stall_hold_%0d got vld=%b pc=%h inst=%h addr=%h want 1/5/%h/6", k, out_valid, out_pc, out_inst, inst_address, word(5));
            end
            if (k < 3) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        end
        for (int j = 6; j < 8; j++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 16'(j) || out_inst !== word(j)) begin
                errors++; $display("FAIL stall_release_%0d got vld=%b pc=%h want 1/%h", j, out_valid, out_pc, 16'(j));
            end
        end
    endtask

    task automatic test_redirect();
        restart();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 16'd9) begin
            errors++; $display("FAIL redir_pre got vld=%b pc=%h want 1/9", out_valid, out_pc);
        end
        step(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || inst_address !== 16'h0040) begin
            errors++; $display("FAIL redir_flush got vld=%b addr=%h want 0/0040", out_valid, inst_address);
        end
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0040 || out_inst !== word(16'h40)) begin
            errors++; $display("FAIL redir_first got vld=%b pc=%h inst=%h want 1/0040/%h", out_valid, out_pc, out_inst, word(16'h40));
        end
        step(1'b1, 1'b1, 16'h0123, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || inst_address !== 16'h0023) begin
            errors++; $display("FAIL redir_mask got vld=%b addr=%h want 0/0023", out_valid, inst_address);
        end
        step(1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 16'((254 + j) % 256)) begin
                errors++; $display("FAIL redir_wrap_%0d got vld=%b pc=%h want 1/%h", j, out_valid, out_pc, 16'((254 + j) % 256));
            end
        end
    endtask

    task automatic test_done();
        restart();
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 16'(i) || out_inst !== word(i)) begin
                errors++; $display("FAIL run_%0d got vld=%b pc=%h want 1/%h", i, out_valid, out_pc, 16'(i));
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || inst_address !== 16'd199) begin
            errors++; $display("FAIL done_enter got done=%b busy=%b addr=%0d want 1/0/199", done, busy, inst_address);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
            checks++;
            if (done !== 1'b1 || out_valid !== 1'b0 || inst_address !== 16'd199) begin
                errors++; $display("FAIL done_hold_%0d got done=%b vld=%b addr=%0d want 1/0/199", k, done, out_valid, inst_address);
            end
        end
        step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || inst_address !== 16'h0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL done_restart got busy=%b done=%b addr=%h vld=%b want 1/0/0/0", busy, done, inst_address, out_valid);
        end
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0) begin
            errors++; $display("FAIL done_restart_pc got vld=%b pc=%h want 1/0", out_valid, out_pc);
        end
        // Jump near the end, reach DONE again, then start and redirect together
        step(1'b1, 1'b1, 16'd197, 1'b0, 1'b0);
        for (int j = 197; j < 200; j++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 16'(j)) begin
                errors++; $display("FAIL tail_%0d got vld=%b pc=%0d want 1/%0d", j, out_valid, out_pc, j);
            end
        end
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0030, 1'b1, 1'b0);
        checks++;
        if (busy !== 1'b1 || inst_address !== 16'h0030) begin
            errors++; $display("FAIL done_redir_wins got busy=%b addr=%h want 1/0030", busy, inst_address);
        end
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0030) begin
            errors++; $display("FAIL done_redir_pc got vld=%b pc=%h want 1/0030", out_valid, out_pc);
        end
    endtask

    task automatic test_reset_mid();
        restart();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre got vld=%b want 1", out_valid);
        end
        step(1'b1, 1'b1, 16'h0077, 1'b1, 1'b1);
        checks++;
        if ({out_valid, busy, done} !== 3'b000 || inst_address !== 16'h0 || out_pc !== 16'h0 ||
            out_inst !== 32'h0 || fetch_count !== 32'h0) begin
            errors++; $display("FAIL rstmid_state got flags=%b addr=%h pc=%h inst=%h cnt=%0d want 000/0/0/0/0", {out_valid, busy, done}, inst_address, out_pc, out_inst, fetch_count);
        end
        for (int k = 0; k < 4; k++) begin
            // redirect in IDLE is ignored as well
            step(1'b1, (k == 3), 16'h0050, 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || inst_address !== 16'h0) begin
                errors++; $display("FAIL idle_%0d got vld=%b busy=%b addr=%h want 0/0/0", k, out_valid, busy, inst_address);
            end
        end
    endtask

    task automatic test_fetch_count();
        logic [31:0] exp_cnt;
`ifdef FETCH_COUNT_EN
        exp_cnt = 32'd10;
`else
        exp_cnt = 32'd0;
`endif
        restart();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        checks++;
        if (fetch_count !== exp_cnt || out_pc !== 16'h0014) begin
            errors++; $display("FAIL fetch_count got cnt=%0d pc=%h want %0d/0014", fetch_count, out_pc, exp_cnt);
        end
    endtask

    // Random ready/redirect traffic checked against the expected delivery order
    task automatic test_random();
        int          exp_pc;
        logic [31:0] exp_cnt;
        logic        rdy, rv, prev_rv, prev2_rv, prev_stall;
        logic [15:0] rpc, held_pc;
        logic [31:0] held_inst;
        restart();
        exp_pc = 0; exp_cnt = 0;
        prev_rv = 1'b0; prev2_rv = 1'b0; prev_stall = 1'b0;
        held_pc = '0; held_inst = '0;
        for (int c = 0; c < 1500; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 24) == 0);
            rpc = 16'($urandom);
            if (prev_rv) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL rnd_flush c=%0d got vld=%b want 0", c, out_valid);
                end
            end else if (prev2_rv) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++; $display("FAIL rnd_refill c=%0d got vld=%b want 1", c, out_valid);
                end
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== held_pc || out_inst !== held_inst) begin
                    errors++; $display("FAIL rnd_stable c=%0d got vld=%b pc=%h want 1/%h", c, out_valid, out_pc, held_pc);
                end
            end
            if (out_valid === 1'b1 && rdy) begin
                checks++;
                if (exp_pc < 0 || out_pc !== 16'(exp_pc) || out_inst !== word(exp_pc)) begin
                    errors++; $display("FAIL rnd_deliver c=%0d got pc=%h inst=%h want pc=%0d", c, out_pc, out_inst, exp_pc);
                end
                exp_cnt = exp_cnt + 1;
                exp_pc  = (exp_pc == 199) ? -1 : (exp_pc + 1) % 256;
            end
            if (rv) exp_pc = int'(rpc) % 256;
            prev_stall = (out_valid === 1'b1) && !rdy && !rv;
            held_pc = out_pc; held_inst = out_inst;
            prev2_rv = prev_rv; prev_rv = rv;
            step(rdy, rv, rpc, 1'b0, 1'b0);
        end
`ifndef FETCH_COUNT_EN
        exp_cnt = 32'd0;
`endif
        checks++;
        if (fetch_count !== exp_cnt) begin
            errors++; $display("FAIL rnd_count got %0d want %0d", fetch_count, exp_cnt);
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = word(k);
        reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_done();
        test_reset_mid();
        test_fetch_count();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the 256-word, combinational-read instruction memory.
- Holds the program counter and drives inst_address; captures read_data the same cycle.
- Presents {pc, instruction} to decode through a one-entry valid/ready output register.
- Handles start, branch redirect and end-of-program stop.

Parameters:
- ADDR_W, 16, width of inst_address / pc.
- DATA_W, 32, instruction width.
- MEM_DEPTH, 256, memory words; power of two; pc wraps modulo MEM_DEPTH.
- RESET_PC, 0, pc value after reset and on start.
- LAST_PC, 199, last program word; after it is fetched the block enters DONE.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins fetching at RESET_PC.
- inst_address  output  ADDR_W  word address to instruction memory; equals pc register.
- read_data  input  DATA_W  word from instruction memory, valid in the same cycle.
- redirect_valid  input  1  branch/jump taken; flush and reload pc.
- redirect_pc  input  ADDR_W  redirect target.
- out_valid  output  1  out_inst/out_pc hold a valid instruction.
- out_ready  input  1  decode accepts when out_valid && out_ready.
- out_inst  output  DATA_W  captured instruction.
- out_pc  output  ADDR_W  address out_inst was fetched from.
- busy  output  1  state == RUN.
- done  output  1  state == DONE.
- fetch_count  output  32  accepted-instruction count (optional feature).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset. All state updates occur on the rising edge of clk.
- Reset values: state = IDLE, pc = RESET_PC, out_valid = 0, out_inst = 0, out_pc = 0, fetch_count = 0. busy and done are 0.
- Reset mid-operation wins over every other input and discards any held instruction.
- inst_address = pc, combinationally from the register. Fetch latency is 1 cycle: address in cycle N, out_valid in cycle N+1.
- States:
  - IDLE: no fetch. start -> RUN with pc = RESET_PC. redirect_valid is ignored.
  - RUN: load = !out_valid || out_ready.
    - On load: out_inst <= read_data, out_pc <= pc, out_valid <= 1.
    - If pc == LAST_PC -> DONE and pc holds. Otherwise pc <= (pc + 1) mod MEM_DEPTH.
    - No load: all registers hold. Output stays stable while out_valid && !out_ready.
  - DONE: no fetch. On out_valid && out_ready, out_valid <= 0. start -> RUN at RESET_PC.
- Redirect (RUN or DONE; highest priority after reset):
  - pc <= redirect_pc & (MEM_DEPTH-1); state <= RUN; out_valid <= 0, even if out_ready is low.
  - A handshake in the same cycle still counts as accepted. No new fetch that cycle.
  - First redirected instruction appears on out_valid one cycle later.
- start in RUN is ignored. start and redirect_valid in the same cycle in DONE: redirect wins.
- Wrap: pc = MEM_DEPTH-1 (when != LAST_PC) increments to 0.
- Handshake: an instruction is delivered exactly once. There are no bubbles while out_ready = 1 in RUN.

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined: fetch_count increments by 1 on every out_valid && out_ready, wraps at 2^32, and is cleared by reset and by start.
- Not defined: no counter logic is built and fetch_count is tied to 0.

Test Plan:
- Reset then start, out_ready = 1, memory word k = 0x1000_0000+k -> out_valid from the 2nd cycle after start; out_pc = 0, 1, 2, … with matching out_inst every cycle.
- out_ready = 0 for 3 cycles while out_pc = 5 -> out_inst/out_pc frozen at 5 and inst_address held at 6; on release, the next accepted out_pc is 6, with no loss and no duplicate.
- Redirect to 0x0040 while out_valid (pc 9) and out_ready = 0 -> next cycle out_valid = 0; the following cycle out_pc = 0x40. Redirect to 0x0123 -> pc = 0x23.
- LAST_PC = 199 -> after out_pc = 199 is accepted: done = 1, out_valid = 0, inst_address stays 199. start -> out_pc = 0 again.
- Assert reset while out_valid = 1 mid-run -> next cycle all outputs at reset values and state IDLE; no fetch until start.
- FETCH_COUNT_EN defined: 10 accepted instructions with 2 stall cycles and a redirect -> fetch_count = 10. Not defined -> fetch_count = 0 throughout.
